// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs PACK_CNT consecutive words into one
// registered valid/ready beat; a flush emits the partially filled beat with a word mask.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK_LG2   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  empty_i,
    output logic                                  rden_o,
    input  logic [DATA_WIDTH-1:0]                 rdata_i,
    input  logic                                  flush_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [(1<<PACK_LG2)*DATA_WIDTH-1:0]   out_data_o,
    output logic [(1<<PACK_LG2)-1:0]              out_mask_o,
    output logic                                  busy_o
);

    localparam int PACK_CNT = 1 << PACK_LG2;
    localparam int BEAT_W   = PACK_CNT * DATA_WIDTH;
    localparam logic [PACK_LG2-1:0] IDX_LAST = PACK_LG2'(PACK_CNT - 1);

    logic [DATA_WIDTH-1:0] r_acc [PACK_CNT-1];
    logic [PACK_LG2-1:0]   r_idx;
    logic [BEAT_W-1:0]     r_out_data;
    logic [PACK_CNT-1:0]   r_out_mask;
    logic                  r_out_valid;
    logic                  r_flush_pend;

    logic                  w_out_free;
    logic                  w_flush_act;
    logic                  w_idx_last;
    logic                  w_rden;
    logic                  w_full_load;
    logic                  w_flush_load;
    logic                  w_beat_load;
    logic [BEAT_W-1:0]     w_new_data;
    logic [PACK_CNT-1:0]   w_new_mask;

    assign w_out_free   = !r_out_valid || out_ready_i;
    assign w_flush_act  = flush_i || r_flush_pend;
    assign w_idx_last   = (r_idx == IDX_LAST);
    assign w_rden       = !empty_i && !w_flush_act && (!w_idx_last || w_out_free);
    assign w_full_load  = w_rden && w_idx_last;
    assign w_flush_load = w_flush_act && (r_idx != '0) && w_out_free;
    assign w_beat_load  = w_full_load || w_flush_load;

    // Slots at or above idx may hold stale words from an earlier beat, so they are zeroed.
    always_comb begin
        w_new_data = '0;
        w_new_mask = '0;
        for (int k = 0; k < PACK_CNT - 1; k++) begin
            if (PACK_LG2'(k) < r_idx) begin
                w_new_data[k*DATA_WIDTH +: DATA_WIDTH] = r_acc[k];
                w_new_mask[k] = 1'b1;
            end
        end
        if (w_full_load) begin
            w_new_data[(PACK_CNT-1)*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
            w_new_mask[PACK_CNT-1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PACK_CNT - 1; k++) begin
            if (w_rden && (r_idx == PACK_LG2'(k))) begin
                r_acc[k] <= rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_out_data   <= '0;
            r_out_mask   <= '0;
            r_out_valid  <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_beat_load) begin
                r_out_data  <= w_new_data;
                r_out_mask  <= w_new_mask;
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end

            if (w_beat_load) begin
                r_idx <= '0;
            end else if (w_rden) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_flush_act) begin
                r_flush_pend <= (r_idx != '0) && !w_out_free;
            end
        end
    end

    // Gating with rst_n makes the pop drop immediately when reset asserts.
    assign rden_o      = w_rden && rst_n;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_mask_o  = r_out_mask;
    assign busy_o      = (r_idx != '0) || r_out_valid || r_flush_pend;

endmodule
